// File: rtl/npu_pool_pkg.sv
// npu_pool_pkg: shared definitions for the max-pool window sequencer.
// Holds the FSM state encoding, default widths and the lane minimum value
// that an idle/cleared max accumulator holds.
package npu_pool_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_DATA_COPIES = 32;
  localparam int DEF_WIN_W       = 4;
  localparam int DEF_NWIN_W      = 16;

  // most negative signed lane value: 1 followed by DATA_WIDTH-1 zeros
  localparam logic [DEF_DATA_WIDTH-1:0] RESULT_MIN = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/npu_pool_obuf.sv
// npu_pool_obuf: one-entry valid/ready result register.
// A capture loads the entry when it is empty or being drained in the same
// cycle. With NPU_POOL_RELU_EN defined, negative lanes are clamped to zero
// on the way in (purely combinational, no added latency).
module npu_pool_obuf import npu_pool_pkg::*; #(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DATA_COPIES = DEF_DATA_COPIES
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cap,
  input  logic [DATA_COPIES*DATA_WIDTH-1:0] cap_data,
  output logic [DATA_COPIES*DATA_WIDTH-1:0] out_data,
  output logic                              out_vld,
  input  logic                              out_rdy
);

  logic [DATA_COPIES-1:0][DATA_WIDTH-1:0] lanes_in;
  logic [DATA_COPIES-1:0][DATA_WIDTH-1:0] lanes_cl;

  assign lanes_in = cap_data;

  for (genvar g = 0; g < DATA_COPIES; g++) begin : g_lane
`ifdef NPU_POOL_RELU_EN
    assign lanes_cl[g] = lanes_in[g][DATA_WIDTH-1] ? '0 : lanes_in[g];
`else
    assign lanes_cl[g] = lanes_in[g];
`endif
  end

  // load on capture when the slot is free, otherwise drop valid on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (cap && (!out_vld || out_rdy)) begin
      out_vld  <= 1'b1;
      out_data <= lanes_cl;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/npu_pool_seq.sv
// npu_pool_seq: window sequencer for the max-pooling PE array.
// Streams input beats into the accumulator, issues clear on each window's
// last beat, captures the pooled result into a one-entry output buffer and
// reports job completion. Optional ReLU clamp: define NPU_POOL_RELU_EN.
module npu_pool_seq import npu_pool_pkg::*; #(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DATA_COPIES = DEF_DATA_COPIES,
  parameter int WIN_W       = DEF_WIN_W,
  parameter int NWIN_W      = DEF_NWIN_W
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_start,
  input  logic [WIN_W-1:0]                    i_cfg_win,
  input  logic [NWIN_W-1:0]                   i_cfg_nwin,
  input  logic [DATA_COPIES*DATA_WIDTH-1:0]   i_in_data,
  input  logic                                i_in_vld,
  output logic                                o_in_rdy,
  output logic [DATA_COPIES*DATA_WIDTH-1:0]   o_mdata,
  output logic                                o_mdata_vld,
  output logic                                o_max_clear,
  output logic                                o_max_en,
  input  logic [DATA_COPIES*2*DATA_WIDTH-1:0] i_max_result,
  output logic [DATA_COPIES*DATA_WIDTH-1:0]   o_out_data,
  output logic                                o_out_vld,
  input  logic                                i_out_rdy,
  output logic                                o_busy,
  output logic                                o_done
);

  localparam int BW = DATA_COPIES * DATA_WIDTH;

  state_t            state;
  logic [WIN_W-1:0]  cfg_win;
  logic [WIN_W-1:0]  beat_cnt;
  logic [NWIN_W-1:0] cfg_nwin;
  logic [NWIN_W-1:0] win_cnt;
  logic              last_beat;
  logic              last_win;
  logic              xfer;
  logic              unused_hi;

  // the accumulator exposes a double-width result; only the low half is a max
  assign unused_hi = ^i_max_result[2*BW-1:BW];

  assign last_beat = (beat_cnt == cfg_win);
  assign last_win  = (win_cnt == cfg_nwin);

  // a window's last beat waits until the previous capture is done and the
  // output slot will be free when its own capture lands
  always_comb begin
    o_in_rdy = 1'b0;
    if (state == S_RUN)
      o_in_rdy = !last_beat || (!o_max_clear && (!o_out_vld || i_out_rdy));
  end

  assign xfer = i_in_vld && o_in_rdy;

  // job control FSM: config latch, beat/window counters, enable, busy, done
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      cfg_win  <= '0;
      cfg_nwin <= '0;
      beat_cnt <= '0;
      win_cnt  <= '0;
      o_max_en <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            cfg_win  <= i_cfg_win;
            cfg_nwin <= i_cfg_nwin;
            beat_cnt <= '0;
            win_cnt  <= '0;
            o_max_en <= 1'b1;
            o_busy   <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (last_beat) begin
              beat_cnt <= '0;
              win_cnt  <= win_cnt + 1'b1;
              if (last_win) state <= S_DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // final capture done and its result handed off
          if (!o_max_clear && o_out_vld && i_out_rdy) begin
            o_max_en <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // registered beat and clear toward the accumulator
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mdata     <= '0;
      o_mdata_vld <= 1'b0;
      o_max_clear <= 1'b0;
    end else begin
      o_mdata_vld <= xfer;
      o_max_clear <= xfer && last_beat;
      if (xfer) o_mdata <= i_in_data;
    end
  end

  // the cycle carrying clear is the one whose combinational max is final
  npu_pool_obuf #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DATA_COPIES (DATA_COPIES)
  ) u_obuf (
    .clk      (i_clk),
    .rst      (i_rst),
    .cap      (o_max_clear),
    .cap_data (i_max_result[BW-1:0]),
    .out_data (o_out_data),
    .out_vld  (o_out_vld),
    .out_rdy  (i_out_rdy)
  );

endmodule

// File: tb/tb_npu_pool_seq.sv
// tb_npu_pool_seq: scoreboard bench for npu_pool_seq with an attached
// behavioural max-accumulator. Expected window maxima come from a per-lane
// running max over accepted beats; a monitor pops them on each output
// handshake.
module tb_npu_pool_seq;
  import npu_pool_pkg::*;

  localparam int DW = 8;
  localparam int DC = 32;
  localparam int WW = 4;
  localparam int NW = 16;
  localparam int BW = DW * DC;

  typedef logic [BW-1:0] beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_start;
  logic [WW-1:0]   i_cfg_win;
  logic [NW-1:0]   i_cfg_nwin;
  logic [BW-1:0]   i_in_data;
  logic            i_in_vld;
  logic            o_in_rdy;
  logic [BW-1:0]   o_mdata;
  logic            o_mdata_vld;
  logic            o_max_clear;
  logic            o_max_en;
  logic [2*BW-1:0] i_max_result;
  logic [BW-1:0]   o_out_data;
  logic            o_out_vld;
  logic            i_out_rdy;
  logic            o_busy;
  logic            o_done;

  always #5 clk = ~clk;

  npu_pool_seq #(.DATA_WIDTH(DW), .DATA_COPIES(DC), .WIN_W(WW), .NWIN_W(NW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_cfg_win(i_cfg_win),
    .i_cfg_nwin(i_cfg_nwin), .i_in_data(i_in_data), .i_in_vld(i_in_vld),
    .o_in_rdy(o_in_rdy), .o_mdata(o_mdata), .o_mdata_vld(o_mdata_vld),
    .o_max_clear(o_max_clear), .o_max_en(o_max_en), .i_max_result(i_max_result),
    .o_out_data(o_out_data), .o_out_vld(o_out_vld), .i_out_rdy(i_out_rdy),
    .o_busy(o_busy), .o_done(o_done)
  );

  // behavioural max accumulator: result includes the beat presented now
  logic [DC-1:0][DW-1:0] acc_q, acc_res, mdata_l;
  assign mdata_l = o_mdata;
  always_comb begin
    acc_res = acc_q;
    for (int l = 0; l < DC; l++)
      if (o_mdata_vld && $signed(mdata_l[l]) > $signed(acc_q[l])) acc_res[l] = mdata_l[l];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= {DC{RESULT_MIN}};
    else if (!o_max_en || o_max_clear) acc_q <= {DC{RESULT_MIN}};
    else if (o_mdata_vld) acc_q <= acc_res;
  end
  assign i_max_result = {{BW{1'b1}}, acc_res};

  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  beat_t exp_q[$];
  int    lat_q[$];
  bit    lat_chk = 1'b0;
  bit    prev_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: compare each accepted result against the scoreboard head
  initial forever begin
    @(negedge clk);
    #1;
    if (rst) prev_vld = 1'b0;
    else begin
      if (lat_chk && o_out_vld && !prev_vld && lat_q.size() > 0)
        chk("latency_cycle", cyc, lat_q.pop_front());
      prev_vld = o_out_vld;
      if (o_out_vld && i_out_rdy) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_result: got %h expected none", o_out_data);
        end else chk("result", o_out_data, exp_q.pop_front());
      end
    end
  end

  task automatic chk_zero_outputs(input string name);
    chk({name, "_ctl"}, {o_in_rdy, o_mdata_vld, o_max_clear, o_max_en, o_out_vld, o_busy, o_done}, '0);
    chk({name, "_mdata"}, o_mdata, '0);
    chk({name, "_out_data"}, o_out_data, '0);
  endtask

  task automatic do_reset();
    i_start = 0; i_in_vld = 0; i_out_rdy = 0; rst = 1;
    #1;
    chk_zero_outputs("reset");
    repeat (2) @(negedge clk);
    exp_q.delete(); lat_q.delete();
    rst = 0;
  endtask

  function automatic beat_t gen(input int dmode, input int idx);
    beat_t b;
    for (int l = 0; l < DC; l++) b[l*DW +: DW] = DW'($urandom);
    if (dmode == 1) begin
      case (idx % 4)
        0: b[DW-1:0] = 8'sd5;
        1: b[DW-1:0] = -8'sd7;
        2: b[DW-1:0] = 8'sd12;
        default: b[DW-1:0] = 8'sd3;
      endcase
    end else if (dmode == 2) begin
      for (int l = 0; l < DC; l++) b[l*DW +: DW] = (idx % 2 == 0) ? -8'sd128 : -8'sd3;
    end
    return b;
  endfunction

  // rdy_mode: 0 always ready, 1 random, 2 low for 30 cycles then high
  task automatic run_job(input int win, input int nwin, input int vld_pct, input int rdy_mode,
                         input int dmode, input bit start_mid, input int abort_at);
    int total, idx, bi;
    bit done_seen, prev_hs, hs, last_i;
    logic signed [DW-1:0] mx[DC];
    logic signed [DW-1:0] v;
    beat_t e;
    total = (win + 1) * (nwin + 1);
    idx = 0; done_seen = 0; prev_hs = 0;
    @(negedge clk);
    i_cfg_win = WW'(win); i_cfg_nwin = NW'(nwin); i_start = 1;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (abort_at >= 0 && idx == abort_at) begin
        i_in_vld = 0; i_start = 0;
        rst = 1;
        #1;
        chk_zero_outputs("abort");
        exp_q.delete(); lat_q.delete();
        @(negedge clk);
        rst = 0;
        return;
      end
      i_start = start_mid && (t == 5);
      i_cfg_win = WW'($urandom); i_cfg_nwin = NW'($urandom);
      i_out_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(99) < 50) : (t >= 30);
      if (idx < total && $urandom_range(99) < vld_pct) begin
        i_in_vld = 1; i_in_data = gen(dmode, idx);
      end else begin
        i_in_vld = 0; i_in_data = beat_t'({$urandom, $urandom, $urandom, $urandom});
      end
      #1;
      if (t == 0) chk("busy_after_start", o_busy, 1);
      bi = idx % (win + 1);
      last_i = (bi == win);
      if (idx < total && last_i && o_out_vld && !i_out_rdy)
        chk("rdy_last_blocked", o_in_rdy, 0);
      if (win == 0 && idx < total && rdy_mode == 0) chk("rdy_alternate", o_in_rdy, !prev_hs);
      else if (win == 0 && idx < total && prev_hs) chk("rdy_after_last", o_in_rdy, 0);
      hs = i_in_vld && o_in_rdy;
      if (hs) begin
        for (int l = 0; l < DC; l++) begin
          v = $signed(i_in_data[l*DW +: DW]);
          if (bi == 0 || v > mx[l]) mx[l] = v;
        end
        if (last_i) begin
          for (int l = 0; l < DC; l++) begin
            v = mx[l];
`ifdef NPU_POOL_RELU_EN
            if (v < 0) v = '0;
`endif
            e[l*DW +: DW] = v;
          end
          exp_q.push_back(e);
          if (lat_chk) lat_q.push_back(cyc + 2);
        end
        idx++;
      end
      prev_hs = hs;
      if (o_done) begin
        chk("beats_before_done", idx, total);
        chk("results_before_done", exp_q.size(), 0);
        chk("busy_at_done", o_busy, 0);
        done_seen = 1;
        break;
      end
    end
    i_in_vld = 0; i_start = 0;
    if (!done_seen) begin
      n_chk++; n_fail++;
      $display("FAIL job_timeout: got no done expected done (win=%0d nwin=%0d)", win, nwin);
      do_reset();
    end else begin
      @(negedge clk);
      #1;
      chk("done_single_pulse", o_done, 0);
    end
  endtask

  initial begin
    i_start = 0; i_cfg_win = '0; i_cfg_nwin = '0; i_in_data = '0;
    i_in_vld = 0; i_out_rdy = 0; rst = 1;
    do_reset();
    lat_chk = 1;
    run_job(3, 0, 100, 0, 1, 0, -1);
    lat_chk = 0;
    run_job(1, 2, 100, 0, 2, 0, -1);
    run_job(0, 3, 100, 0, 0, 0, -1);
    run_job(1, 1, 100, 2, 0, 0, -1);
    run_job(2, 3, 70, 1, 0, 1, -1);
    run_job(3, 2, 100, 0, 0, 0, 2);
    run_job(3, 1, 100, 0, 0, 0, -1);
    for (int k = 0; k < 6; k++)
      run_job($urandom_range(0, 4), $urandom_range(0, 3), 60, 1, 0, 0, -1);
    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
